// File: rtl/vga_pixel_port.sv
// Memory-mapped VGA pixel-write port: X/Y/colour staging registers feeding a
// show-ahead pixel FIFO drained over a valid/ready handshake.
module vga_pixel_port #(
  parameter int unsigned XW    = 16,
  parameter int unsigned YW    = 16,
  parameter int unsigned CW    = 9,
  parameter int unsigned DEPTH = 8,
  parameter logic [3:0]  PAGE  = 4'h4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [31:0]   realaddr,
  input  logic [31:0]   dout,
  input  logic          W,
  output logic          sel,
  output logic [31:0]   rdata,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic [CW-1:0] pix_colour,
  output logic          pix_valid,
  input  logic          pix_ready
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned EW   = XW + YW + CW;

  localparam logic [4:0] OffX      = 5'h00;
  localparam logic [4:0] OffY      = 5'h04;
  localparam logic [4:0] OffColour = 5'h08;
  localparam logic [4:0] OffWrite  = 5'h0C;
  localparam logic [4:0] OffStatus = 5'h10;
  localparam logic [4:0] OffCtrl   = 5'h14;

  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [CW-1:0]   colour_q, colour_d;
  logic            autoinc_q, autoinc_d;
  logic            ovf_q, ovf_d;
  logic [CntW-1:0] count_q, count_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [31:0]     rdata_d;
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   head;

  logic [4:0] off;
  logic       wr, empty, full, pop, push_req, push_ok, drop, ovf_clr;

  assign sel       = (realaddr[15:12] == PAGE);
  assign off       = realaddr[4:0];
  assign wr        = sel & W;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CntW'(DEPTH));
  assign pix_valid = ~empty;
  assign pop       = pix_valid & pix_ready;
  assign push_req  = wr & (off == OffWrite) & dout[0];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;
  assign ovf_clr   = wr & (off == OffCtrl) & dout[0];

  assign head       = mem[rptr_q];
  assign pix_x      = head[EW-1 -: XW];
  assign pix_y      = head[YW+CW-1 -: YW];
  assign pix_colour = head[CW-1:0];

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    autoinc_d = autoinc_q;
    ovf_d     = ovf_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q + CntW'(push_ok) - CntW'(pop);

    if (wr && off == OffX)      x_d       = dout[XW-1:0];
    if (wr && off == OffY)      y_d       = dout[YW-1:0];
    if (wr && off == OffColour) colour_d  = dout[CW-1:0];
    if (wr && off == OffCtrl)   autoinc_d = dout[1];
    if (push_ok && autoinc_q)   x_d       = x_q + XW'(1);
    if (push_ok)                wptr_d    = wptr_q + AW'(1);
    if (pop)                    rptr_d    = rptr_q + AW'(1);

    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;

    rdata_d = '0;
    if (sel && !W) begin
      case (off)
        OffX:      rdata_d = 32'(x_q);
        OffY:      rdata_d = 32'(y_q);
        OffColour: rdata_d = 32'(colour_q);
        OffStatus: begin
          rdata_d[0]           = empty;
          rdata_d[1]           = full;
          rdata_d[2]           = ovf_q;
          rdata_d[8 +: CntW]   = count_q;
        end
        OffCtrl:   rdata_d[1] = autoinc_q;
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      autoinc_q <= 1'b0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      rdata     <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      autoinc_q <= autoinc_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      rdata     <= rdata_d;
    end
  end

  // Storage needs no reset: validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= {x_q, y_q, colour_q};
  end

endmodule

// File: tb/tb_vga_pixel_port.sv
// Directed self-checking bench for vga_pixel_port with default parameters.
module tb_vga_pixel_port;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] realaddr;
  logic [31:0] dout;
  logic        W;
  logic        sel;
  logic [31:0] rdata;
  logic [15:0] pix_x;
  logic [15:0] pix_y;
  logic [8:0]  pix_colour;
  logic        pix_valid;
  logic        pix_ready;

  int tests = 0;
  int fails = 0;
  logic [31:0] r;
  logic [15:0] exp_x [8];

  vga_pixel_port dut (
    .clk        (clk),
    .resetn     (resetn),
    .realaddr   (realaddr),
    .dout       (dout),
    .W          (W),
    .sel        (sel),
    .rdata      (rdata),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_colour (pix_colour),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drives one write cycle; returns on the negedge after the capturing edge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    realaddr = addr;
    dout     = data;
    W        = 1'b1;
    @(negedge clk);
    W        = 1'b0;
    realaddr = 32'h0;
    dout     = 32'h0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    realaddr = addr;
    W        = 1'b0;
    @(negedge clk);
    data     = rdata;
    realaddr = 32'h0;
  endtask

  initial begin
    resetn    = 1'b0;
    realaddr  = 32'h0;
    dout      = 32'h0;
    W         = 1'b0;
    pix_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, pix_valid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    resetn = 1'b1;

    rd(32'h4010, r);
    chk("rst_status", r, 32'h0000_0001);
    realaddr = 32'h5010;
    #1 chk("sel_off_page", {31'd0, sel}, 32'd0);
    rd(32'h5010, r);
    chk("rd_off_page", r, 32'd0);

    // Single pixel through an always-ready adapter
    pix_ready = 1'b1;
    wr(32'h4000, 32'd5);
    wr(32'h4004, 32'd7);
    wr(32'h4008, 32'h1FF);
    wr(32'h400C, 32'd0);
    chk("noop_write", {31'd0, pix_valid}, 32'd0);
    wr(32'h400C, 32'd1);
    chk("push_valid", {31'd0, pix_valid}, 32'd1);
    chk("push_x", {16'd0, pix_x}, 32'd5);
    chk("push_y", {16'd0, pix_y}, 32'd7);
    chk("push_c", {23'd0, pix_colour}, 32'h1FF);
    @(negedge clk);
    chk("popped_valid", {31'd0, pix_valid}, 32'd0);
    rd(32'h4000, r); chk("rd_x", r, 32'd5);
    rd(32'h4004, r); chk("rd_y", r, 32'd7);
    rd(32'h4008, r); chk("rd_c", r, 32'h1FF);

    // Overflow: 9 pushes into an 8-deep FIFO with adapter stalled
    pix_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr(32'h4000, i);
      wr(32'h400C, 32'd1);
    end
    rd(32'h4010, r);
    chk("full_ovf_status", r, 32'h0000_0806);
    chk("head_x", {16'd0, pix_x}, 32'd0);
    wr(32'h4014, 32'd1);
    rd(32'h4010, r);
    chk("ovf_cleared", r, 32'h0000_0802);
    rd(32'h4014, r);
    chk("ctrl_strobe_rd", r, 32'd0);

    // Push while full and popping in the same cycle
    wr(32'h4000, 32'h20);
    @(negedge clk);
    realaddr  = 32'h400C;
    dout      = 32'd1;
    W         = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    W         = 1'b0;
    realaddr  = 32'h0;
    pix_ready = 1'b0;
    rd(32'h4010, r);
    chk("full_push_pop", r, 32'h0000_0802);
    for (int k = 0; k < 7; k++) exp_x[k] = 16'(k + 1);
    exp_x[7] = 16'h20;
    pix_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain_x%0d", k), {pix_valid, 15'd0, pix_x}, {1'b1, 15'd0, exp_x[k]});
      @(negedge clk);
    end
    pix_ready = 1'b0;
    chk("drained_valid", {31'd0, pix_valid}, 32'd0);

    // Auto-increment wraps X modulo 2^16
    wr(32'h4014, 32'd2);
    wr(32'h4000, 32'hFFFE);
    repeat (3) wr(32'h400C, 32'd1);
    rd(32'h4000, r);   chk("autoinc_x", r, 32'd1);
    rd(32'h4014, r);   chk("ctrl_rd", r, 32'd2);
    rd(32'h4010, r);   chk("ai_status", r, 32'h0000_0300);
    exp_x[0] = 16'hFFFE; exp_x[1] = 16'hFFFF; exp_x[2] = 16'h0000;
    pix_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ai_drain%0d", k), {15'd0, pix_valid, pix_x}, {15'd0, 1'b1, exp_x[k]});
      @(negedge clk);
    end
    pix_ready = 1'b0;

    // Asynchronous reset mid-drain
    wr(32'h4004, 32'd3);
    repeat (3) wr(32'h400C, 32'd1);
    pix_ready = 1'b1;
    @(negedge clk);
    #2 resetn = 1'b0;
    #1 chk("async_rst_valid", {31'd0, pix_valid}, 32'd0);
    pix_ready = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    rd(32'h4010, r); chk("rst2_status", r, 32'h0000_0001);
    rd(32'h4000, r); chk("rst2_x", r, 32'd0);
    rd(32'h4004, r); chk("rst2_y", r, 32'd0);
    rd(32'h4008, r); chk("rst2_c", r, 32'd0);
    rd(32'h4014, r); chk("rst2_ctrl", r, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
